mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage. Takes EX/MEM-latched instruction state, runs the data-memory load/store handshake against the dcache/arbiter, and registers the result into the MEM/WB latch that feeds writeback.
- Stalls the upstream pipeline while a data access is outstanding.
- Sole driver of the MEM/WB interface fields: alu_result, dmemload, instr_npc, wsel, wdat_source, wen, halt, valid.

Parameters:
- WORD_W, 32, data/address width.
- REG_W, 5, register-select width.

Ports:
- CLK  in  1  clock, all state on rising edge.
- nRST  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX/MEM holds a real instruction (0 = bubble).
- ex_alu_result  in  WORD_W  ALU result; also the memory address.
- ex_store_data  in  WORD_W  store data.
- ex_instr_npc  in  WORD_W  PC+4 of instruction.
- ex_wsel  in  REG_W  destination register.
- ex_wdat_source  in  2  0=WRITE_ALU, 1=WRITE_RAM, 2=WRITE_NPC.
- ex_wen  in  1  instruction writes a register.
- ex_dren  in  1  load.
- ex_dwen  in  1  store.
- ex_halt  in  1  halt instruction.
- flush  in  1  squash incoming EX/MEM instruction.
- dhit  in  1  data memory completes access this cycle.
- dmemload  in  WORD_W  load data, valid when dhit=1.
- dmemREN  out  1  read request.
- dmemWEN  out  1  write request.
- dmemaddr  out  WORD_W  access address.
- dmemstore  out  WORD_W  store data.
- mem_stall  out  1  hold IF/ID/EX and EX/MEM.
- wb_valid, wb_alu_result, wb_dmemload, wb_instr_npc, wb_wsel, wb_wdat_source, wb_wen, wb_halt  out  (1, WORD_W, WORD_W, WORD_W, REG_W, 2, 1, 1)  MEM/WB latch.

Behaviour:
- Reset (nRST=0, async): state IDLE; every wb_* output 0; dmemREN, dmemWEN, mem_stall 0; dmemaddr, dmemstore 0; internal request registers 0.
- An incoming instruction is "live" when ex_valid=1, flush=0 and state is not HALTED.
- IDLE, live, no memory op (ex_dren=ex_dwen=0):
  - Next edge latches all wb_* from ex_* with wb_valid=1 and wb_dmemload=0.
  - Latency 1; mem_stall stays 0.
- IDLE, live, memory op:
  - dmemREN=ex_dren, dmemWEN=ex_dwen, dmemaddr=ex_alu_result, dmemstore=ex_store_data, all combinational, same cycle.
  - dhit=1 same cycle: latch the MEM/WB fields on the next edge; wb_dmemload=dmemload for a load, 0 for a store; stay IDLE; mem_stall 0.
  - dhit=0: mem_stall=1 combinationally. Next edge captures the request and all ex_* into internal registers, goes to ACCESS, and latches a bubble (wb_valid=0, wb_wen=0).
- ACCESS:
  - Request driven from internal registers; mem_stall=1 until dhit.
  - Every edge without dhit latches a bubble.
  - On dhit, mem_stall=0 that cycle; next edge latches the captured instruction with wb_dmemload (dmemload for loads), wb_valid=1, and returns to IDLE.
  - The request stays asserted and stable until dhit; it is never dropped or altered.
- dren and dwen both 1 is illegal; read takes priority and dmemWEN=0.
- flush:
  - In IDLE, flush=1 turns the incoming instruction into a bubble; no memory request is issued.
  - In ACCESS, flush is ignored: the outstanding access is older and must complete.
- Halt:
  - A live instruction with ex_halt=1 latches with wb_halt=1 and moves to HALTED.
  - In HALTED, wb_halt stays 1, wb_valid=0, wb_wen=0, no requests, mem_stall=0.
  - Only reset exits HALTED.
- Bubble inputs (ex_valid=0) latch wb_valid=0 and wb_wen=0; other wb_* fields are don't-care but driven as 0.
- Reset asserted mid-ACCESS aborts immediately: outputs go to reset values and the request deasserts asynchronously.
- No internal address or width arithmetic; all fields pass through at their declared widths.

Test Plan:
- Reset, then ALU instr (ex_alu_result=0x0000_1234, wsel=5, wdat_source=0, wen=1) -> one edge later wb_valid=1, wb_alu_result=0x1234, wb_wsel=5; mem_stall never 1.
- Load at addr 0x100, dhit=1 same cycle with dmemload=0xDEAD_BEEF -> dmemREN=1, dmemaddr=0x100 that cycle; next edge wb_dmemload=0xDEADBEEF, wb_wdat_source=1, no stall.
- Store addr 0x200, data 0xCAFE, dhit after 3 wait cycles while ex_* inputs are changed -> dmemWEN=1, addr=0x200, store=0xCAFE held stable; mem_stall=1 for 3 cycles; 3 bubbles then wb_valid=1, wb_dmemload=0.
- Load waiting in ACCESS, flush=1 asserted -> access still completes; on dhit the load retires with wb_valid=1. Flush in IDLE with a store -> dmemWEN stays 0, bubble latched.
- Halt instr followed by a valid ALU instr -> wb_halt=1 persists; second instr never appears (wb_valid=0); no dmem requests.
- nRST pulsed low during ACCESS -> dmemREN=0 immediately, all wb_*=0, state IDLE; the next instruction processes normally.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the dcache load/store handshake and the MEM/WB latch; 1-cycle latency on a hit.
// A miss asserts mem_stall until dhit and latches bubbles meanwhile; HALTED is left only through nRST.
module mem_stage #(
   parameter int WORD_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ex_valid,
   input  logic [WORD_W-1:0] ex_alu_result,
   input  logic [WORD_W-1:0] ex_store_data,
   input  logic [WORD_W-1:0] ex_instr_npc,
   input  logic [REG_W-1:0]  ex_wsel,
   input  logic [1:0]        ex_wdat_source,
   input  logic              ex_wen,
   input  logic              ex_dren,
   input  logic              ex_dwen,
   input  logic              ex_halt,
   input  logic              flush,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dmemload,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [WORD_W-1:0] dmemaddr,
   output logic [WORD_W-1:0] dmemstore,
   output logic              mem_stall,
   output logic              wb_valid,
   output logic [WORD_W-1:0] wb_alu_result,
   output logic [WORD_W-1:0] wb_dmemload,
   output logic [WORD_W-1:0] wb_instr_npc,
   output logic [REG_W-1:0]  wb_wsel,
   output logic [1:0]        wb_wdat_source,
   output logic              wb_wen,
   output logic              wb_halt
);

   typedef enum logic [1:0] {IDLE, ACCESS, HALTED} state_t;

   typedef struct packed {
      logic [WORD_W-1:0] alu_result;
      logic [WORD_W-1:0] store_data;
      logic [WORD_W-1:0] instr_npc;
      logic [REG_W-1:0]  wsel;
      logic [1:0]        wdat_source;
      logic              wen;
      logic              dren;
      logic              dwen;
      logic              halt;
   } req_t;

   typedef struct packed {
      logic              valid;
      logic [WORD_W-1:0] alu_result;
      logic [WORD_W-1:0] dmemload;
      logic [WORD_W-1:0] instr_npc;
      logic [REG_W-1:0]  wsel;
      logic [1:0]        wdat_source;
      logic              wen;
      logic              halt;
   } wb_t;

   state_t state, state_nxt;
   req_t   cap, cap_nxt, ex_req;
   wb_t    wb, wb_nxt;
   logic   live, ex_mem;

   function automatic wb_t retire(input req_t r, input logic [WORD_W-1:0] ld);
      wb_t w;
      w.valid       = 1'b1;
      w.alu_result  = r.alu_result;
      w.dmemload    = r.dren ? ld : '0;
      w.instr_npc   = r.instr_npc;
      w.wsel        = r.wsel;
      w.wdat_source = r.wdat_source;
      w.wen         = r.wen;
      w.halt        = r.halt;
      return w;
   endfunction

   always_comb begin
      ex_req.alu_result  = ex_alu_result;
      ex_req.store_data  = ex_store_data;
      ex_req.instr_npc   = ex_instr_npc;
      ex_req.wsel        = ex_wsel;
      ex_req.wdat_source = ex_wdat_source;
      ex_req.wen         = ex_wen;
      ex_req.dren        = ex_dren;
      ex_req.dwen        = ex_dwen;
      ex_req.halt        = ex_halt;
   end

   assign live   = ex_valid & ~flush & (state == IDLE);
   assign ex_mem = ex_dren | ex_dwen;

   // Request outputs are gated by nRST so an in-flight access drops the moment reset asserts.
   always_comb begin
      dmemREN   = 1'b0;
      dmemWEN   = 1'b0;
      dmemaddr  = '0;
      dmemstore = '0;
      mem_stall = 1'b0;
      if (nRST) begin
         case (state)
            IDLE: begin
               if (live && ex_mem) begin
                  dmemREN   = ex_dren;
                  dmemWEN   = ex_dwen & ~ex_dren;
                  dmemaddr  = ex_alu_result;
                  dmemstore = ex_store_data;
                  mem_stall = ~dhit;
               end
            end
            ACCESS: begin
               dmemREN   = cap.dren;
               dmemWEN   = cap.dwen & ~cap.dren;
               dmemaddr  = cap.alu_result;
               dmemstore = cap.store_data;
               mem_stall = ~dhit;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      cap_nxt   = cap;
      wb_nxt    = '0;
      case (state)
         IDLE: begin
            if (live) begin
               if (ex_mem && !dhit) begin
                  cap_nxt   = ex_req;
                  state_nxt = ACCESS;
               end else begin
                  wb_nxt = retire(ex_req, dmemload);
                  if (ex_halt) state_nxt = HALTED;
               end
            end
         end
         ACCESS: begin
            // flush is deliberately ignored here: the captured access is older than the flush.
            if (dhit) begin
               wb_nxt    = retire(cap, dmemload);
               cap_nxt   = '0;
               state_nxt = cap.halt ? HALTED : IDLE;
            end
         end
         HALTED: wb_nxt.halt = 1'b1;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         cap   <= '0;
         wb    <= '0;
      end else begin
         state <= state_nxt;
         cap   <= cap_nxt;
         wb    <= wb_nxt;
      end
   end

   assign wb_valid       = wb.valid;
   assign wb_alu_result  = wb.alu_result;
   assign wb_dmemload    = wb.dmemload;
   assign wb_instr_npc   = wb.instr_npc;
   assign wb_wsel        = wb.wsel;
   assign wb_wdat_source = wb.wdat_source;
   assign wb_wen         = wb.wen;
   assign wb_halt        = wb.halt;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change 1ns after each rising edge, outputs sampled before the next edge.
module tb_mem_stage;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   logic              CLK, nRST;
   logic              ex_valid, ex_wen, ex_dren, ex_dwen, ex_halt, flush, dhit;
   logic [WORD_W-1:0] ex_alu_result, ex_store_data, ex_instr_npc, dmemload;
   logic [REG_W-1:0]  ex_wsel;
   logic [1:0]        ex_wdat_source;
   logic              dmemREN, dmemWEN, mem_stall;
   logic [WORD_W-1:0] dmemaddr, dmemstore;
   logic              wb_valid, wb_wen, wb_halt;
   logic [WORD_W-1:0] wb_alu_result, wb_dmemload, wb_instr_npc;
   logic [REG_W-1:0]  wb_wsel;
   logic [1:0]        wb_wdat_source;

   int n_cmp = 0;
   int n_err = 0;

   mem_stage #(.WORD_W(WORD_W), .REG_W(REG_W)) dut (
      .CLK(CLK), .nRST(nRST),
      .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .ex_instr_npc(ex_instr_npc), .ex_wsel(ex_wsel), .ex_wdat_source(ex_wdat_source),
      .ex_wen(ex_wen), .ex_dren(ex_dren), .ex_dwen(ex_dwen), .ex_halt(ex_halt),
      .flush(flush), .dhit(dhit), .dmemload(dmemload),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .mem_stall(mem_stall),
      .wb_valid(wb_valid), .wb_alu_result(wb_alu_result), .wb_dmemload(wb_dmemload),
      .wb_instr_npc(wb_instr_npc), .wb_wsel(wb_wsel), .wb_wdat_source(wb_wdat_source),
      .wb_wen(wb_wen), .wb_halt(wb_halt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      ex_valid = 0; ex_alu_result = '0; ex_store_data = '0; ex_instr_npc = '0;
      ex_wsel = '0; ex_wdat_source = '0; ex_wen = 0; ex_dren = 0; ex_dwen = 0;
      ex_halt = 0; flush = 0; dhit = 0; dmemload = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      nRST = 0;
      #3;
      n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
      n_cmp++; if (wb_halt !== 1'b0) begin n_err++; $display("FAIL reset_wb_halt got %b want 0", wb_halt); end
      n_cmp++; if (wb_alu_result !== 32'h0) begin n_err++; $display("FAIL reset_wb_alu got %h want 0", wb_alu_result); end
      n_cmp++; if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin n_err++; $display("FAIL reset_req got %b want 000", {dmemREN, dmemWEN, mem_stall}); end
      n_cmp++; if (dmemaddr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", dmemaddr); end
      tick();
      nRST = 1;
      tick();
   endtask

   task automatic test_alu();
      ex_valid = 1; ex_alu_result = 32'h0000_1234; ex_instr_npc = 32'h0000_0044;
      ex_wsel = 5'd5; ex_wdat_source = 2'd0; ex_wen = 1;
      #1;
      n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL alu_stall got %b want 0", mem_stall); end
      n_cmp++; if (dmemREN !== 1'b0) begin n_err++; $display("FAIL alu_ren got %b want 0", dmemREN); end
      tick();
      idle_inputs();
      n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL alu_wb_valid got %b want 1", wb_valid); end
      n_cmp++; if (wb_alu_result !== 32'h1234) begin n_err++; $display("FAIL alu_wb_alu got %h want 1234", wb_alu_result); end
      n_cmp++; if (wb_wsel !== 5'd5) begin n_err++; $display("FAIL alu_wb_wsel got %0d want 5", wb_wsel); end
      n_cmp++; if (wb_instr_npc !== 32'h44) begin n_err++; $display("FAIL alu_wb_npc got %h want 44", wb_instr_npc); end
      n_cmp++; if (wb_wen !== 1'b1) begin n_err++; $display("FAIL alu_wb_wen got %b want 1", wb_wen); end
      tick();
      n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL bubble_wb_valid got %b want 0", wb_valid); end
   endtask

   task automatic test_load_hit();
      ex_valid = 1; ex_dren = 1; ex_alu_result = 32'h100; ex_wsel = 5'd7;
      ex_wdat_source = 2'd1; ex_wen = 1; dhit = 1; dmemload = 32'hDEAD_BEEF;
      #1;
      n_cmp++; if (dmemREN !== 1'b1) begin n_err++; $display("FAIL ldhit_ren got %b want 1", dmemREN); end
      n_cmp++; if (dmemaddr !== 32'h100) begin n_err++; $display("FAIL ldhit_addr got %h want 100", dmemaddr); end
      n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL ldhit_stall got %b want 0", mem_stall); end
      tick();
      idle_inputs();
      n_cmp++; if (wb_dmemload !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ldhit_wb_load got %h want deadbeef", wb_dmemload); end
      n_cmp++; if (wb_wdat_source !== 2'd1) begin n_err++; $display("FAIL ldhit_wb_src got %0d want 1", wb_wdat_source); end
      n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL ldhit_wb_valid got %b want 1", wb_valid); end
   endtask

   task automatic test_store_wait();
      ex_valid = 1; ex_dwen = 1; ex_alu_result = 32'h200; ex_store_data = 32'hCAFE;
      ex_wsel = 5'd0; ex_wen = 0; dhit = 0;
      #1;
      n_cmp++; if (mem_stall !== 1'b1) begin n_err++; $display("FAIL st_stall0 got %b want 1", mem_stall); end
      n_cmp++; if (dmemWEN !== 1'b1) begin n_err++; $display("FAIL st_wen0 got %b want 1", dmemWEN); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL st_bubble%0d got %b want 0", i, wb_valid); end
         ex_alu_result = 32'h999 + i; ex_store_data = 32'h1111 * i; ex_dren = i[0];
         dhit = (i == 3);
         #1;
         n_cmp++; if ({dmemWEN, dmemREN} !== 2'b10) begin n_err++; $display("FAIL st_req%0d got %b want 10", i, {dmemWEN, dmemREN}); end
         n_cmp++; if (dmemaddr !== 32'h200 || dmemstore !== 32'hCAFE) begin n_err++; $display("FAIL st_hold%0d got %h/%h want 200/cafe", i, dmemaddr, dmemstore); end
         n_cmp++; if (mem_stall !== (i != 3)) begin n_err++; $display("FAIL st_stall%0d got %b want %b", i, mem_stall, i != 3); end
      end
      tick();
      idle_inputs();
      n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL st_retire_valid got %b want 1", wb_valid); end
      n_cmp++; if (wb_dmemload !== 32'h0 || wb_alu_result !== 32'h200) begin n_err++; $display("FAIL st_retire got %h/%h want 0/200", wb_dmemload, wb_alu_result); end
   endtask

   task automatic test_flush();
      ex_valid = 1; ex_dren = 1; ex_alu_result = 32'h300; ex_wsel = 5'd9;
      ex_wdat_source = 2'd1; ex_wen = 1; dhit = 0;
      tick();
      flush = 1; ex_alu_result = 32'h777; ex_dren = 0; ex_dwen = 1;
      #1;
      n_cmp++; if (dmemREN !== 1'b1 || dmemaddr !== 32'h300) begin n_err++; $display("FAIL fl_access got %b/%h want 1/300", dmemREN, dmemaddr); end
      tick();
      n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL fl_bubble got %b want 0", wb_valid); end
      dhit = 1; dmemload = 32'h55AA;
      tick();
      n_cmp++; if (wb_valid !== 1'b1 || wb_dmemload !== 32'h55AA || wb_wsel !== 5'd9) begin n_err++; $display("FAIL fl_retire got %b/%h/%0d want 1/55aa/9", wb_valid, wb_dmemload, wb_wsel); end
      idle_inputs();
      ex_valid = 1; flush = 1; ex_dwen = 1; ex_alu_result = 32'h400; ex_wen = 1;
      #1;
      n_cmp++; if (dmemWEN !== 1'b0 || mem_stall !== 1'b0) begin n_err++; $display("FAIL fl_idle_req got %b/%b want 0/0", dmemWEN, mem_stall); end
      tick();
      idle_inputs();
      n_cmp++; if (wb_valid !== 1'b0 || wb_wen !== 1'b0) begin n_err++; $display("FAIL fl_idle_wb got %b/%b want 0/0", wb_valid, wb_wen); end
   endtask

   task automatic test_halt();
      ex_valid = 1; ex_halt = 1; ex_alu_result = 32'hAB;
      tick();
      n_cmp++; if (wb_halt !== 1'b1 || wb_valid !== 1'b1) begin n_err++; $display("FAIL halt_latch got %b/%b want 1/1", wb_halt, wb_valid); end
      ex_halt = 0; ex_wen = 1; ex_dren = 1; ex_alu_result = 32'h88; ex_wsel = 5'd4;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++; if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin n_err++; $display("FAIL halt_req%0d got %b want 000", i, {dmemREN, dmemWEN, mem_stall}); end
         tick();
         n_cmp++; if (wb_halt !== 1'b1 || wb_valid !== 1'b0 || wb_wen !== 1'b0) begin n_err++; $display("FAIL halt_hold%0d got %b/%b/%b want 1/0/0", i, wb_halt, wb_valid, wb_wen); end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_access();
      nRST = 0;
      #2;
      n_cmp++; if (wb_halt !== 1'b0) begin n_err++; $display("FAIL rst_exit_halt got %b want 0", wb_halt); end
      nRST = 1;
      tick();
      ex_valid = 1; ex_dren = 1; ex_alu_result = 32'h500; ex_wen = 1; dhit = 0;
      tick();
      n_cmp++; if (dmemREN !== 1'b1 || mem_stall !== 1'b1) begin n_err++; $display("FAIL rst_access got %b/%b want 1/1", dmemREN, mem_stall); end
      #2;
      nRST = 0;
      #1;
      n_cmp++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0 || dmemaddr !== 32'h0) begin n_err++; $display("FAIL rst_abort got %b/%b/%h want 0/0/0", dmemREN, mem_stall, dmemaddr); end
      n_cmp++; if (wb_valid !== 1'b0 || wb_wen !== 1'b0 || wb_alu_result !== 32'h0) begin n_err++; $display("FAIL rst_abort_wb got %b/%b/%h want 0/0/0", wb_valid, wb_wen, wb_alu_result); end
      idle_inputs();
      #1;
      nRST = 1;
      tick();
      ex_valid = 1; ex_alu_result = 32'h77; ex_wsel = 5'd3; ex_wen = 1;
      #1;
      n_cmp++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin n_err++; $display("FAIL rst_idle got %b/%b want 0/0", dmemREN, mem_stall); end
      tick();
      idle_inputs();
      n_cmp++; if (wb_valid !== 1'b1 || wb_alu_result !== 32'h77 || wb_wsel !== 5'd3) begin n_err++; $display("FAIL rst_next got %b/%h/%0d want 1/77/3", wb_valid, wb_alu_result, wb_wsel); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_hit();
      test_store_wait();
      test_flush();
      test_halt();
      test_reset_mid_access();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
